domain_demux: RTL and testbench
===============================

DOMAIN_DEMUX -- requirements
Module: domain_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both domain outputs.
REQ-002 Parameter: SCRUB_CYCLES, default 2, cycles spent scrubbing on a domain switch; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  shared-channel word present; label {L}.
REQ-006 in_sel  input  1  destination domain, 0=D1, 1=D2; label {L}.
REQ-007 in_data  input  WIDTH  shared-channel word; label Dom(in_sel).
REQ-008 in_ready  output  1  word accepted this cycle when in_valid&&in_ready; label {L}.
REQ-009 out1_valid, out1_data  output  1, WIDTH  D1 delivery; label {D1}.
REQ-010 out1_ready  input  1  D1 consumer ready; label {D1}.
REQ-011 out2_valid, out2_data  output  1, WIDTH  D2 delivery; label {D2}.
REQ-012 out2_ready  input  1  D2 consumer ready; label {D2}.
REQ-013 busy  output  1  high whenever state is not IDLE; label {L}.

Function
REQ-014 FSM states: IDLE, HOLD, SCRUB; cur_dom register (1 bit) names the currently open domain.
REQ-015 in_ready SHALL equal (state==IDLE) && (in_sel==cur_dom), combinationally.
REQ-016 IDLE, in_valid, in_sel==cur_dom: capture in_data into out<cur_dom>_data, set out<cur_dom>_valid, go HOLD; latency one edge from acceptance to valid.
REQ-017 IDLE, in_valid, in_sel!=cur_dom: accept nothing, go SCRUB, load scrub counter with SCRUB_CYCLES-1.
REQ-018 IDLE, !in_valid: remain IDLE, outputs unchanged (all zero).
REQ-019 HOLD: out<cur_dom>_valid and data stable until out<cur_dom>_ready high at an edge; on that edge clear valid and data to 0, go IDLE.
REQ-020 Sustained throughput: one word per two cycles within a domain (HOLD then IDLE).
REQ-021 SCRUB: both out*_data and out*_valid held 0; counter decrements each edge; on edge with counter==0, toggle cur_dom, go IDLE.
REQ-022 SCRUB duration exactly SCRUB_CYCLES cycles; in_sel/in_valid changes during SCRUB ignored; after exit the REQ-015 check repeats against the new cur_dom.
REQ-023 The non-open domain's out data SHALL be 0 in every cycle; an out*_data SHALL be nonzero only while its out*_valid is high.
REQ-024 out*_ready of the non-open domain, or while not in HOLD, SHALL have no effect.
REQ-025 No combinational path from in_data to any output; from in_sel only to in_ready.

Reset
REQ-026 rst high: state=IDLE, cur_dom=0 (D1), counter=0, out1_valid=out2_valid=0, out1_data=out2_data=0, busy=0, immediately without clock.
REQ-027 rst asserted mid-HOLD or mid-SCRUB: pending word discarded, no partial delivery after release; first post-reset acceptance only for in_sel=0.

Verification
REQ-028 Reset, in_valid=1, in_sel=0, in_data=8'hA5 -> in_ready=1; next cycle out1_valid=1, out1_data=A5, out2_data=0, busy=1; out1_ready=1 -> following cycle out1_valid=0, out1_data=0, IDLE.
REQ-029 cur_dom=D1, in_valid=1, in_sel=1, data=8'h3C, SCRUB_CYCLES=2 -> in_ready=0 for 3 cycles (IDLE check + 2 SCRUB), busy=1 for 2 cycles; 4th cycle in_ready=1, then out2_data=3C, out1_data=0 throughout.
REQ-030 HOLD on D2 with out2_ready=0 for 10 cycles, out1_ready=1 toggling -> out2_valid/out2_data=3C stable, in_ready=0, out1 stays 0.
REQ-031 rst pulsed (asynchronous, between edges) during SCRUB toward D2 -> all outputs 0 at once; after release in_sel=1 gives in_ready=0 and a fresh SCRUB.
REQ-032 Back-to-back D1 words 01,02,03 with out1_ready=1 always -> delivered in order, one per two cycles, out2_valid never high; random long run with scoreboard: no word delivered to wrong domain, no nonzero data outside valid.

Source files
------------

// File: rtl/domain_demux_if.sv
// Shared-channel input plus the two per-domain delivery channels of domain_demux.
// The master side drives the shared word and consumer readies; the slave side is the demux.
interface domain_demux_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
  logic             out2_valid;
  logic [WIDTH-1:0] out2_data;
  logic             out2_ready;
  logic             busy;

  modport master (
    output in_valid, in_sel, in_data, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data, busy
  );

  modport slave (
    input  in_valid, in_sel, in_data, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data, busy
  );
endinterface

// File: rtl/domain_demux.sv
// Two-domain demultiplexer: forwards words to the open domain and scrubs (all outputs zero)
// for SCRUB_CYCLES cycles before switching the open domain.
module domain_demux #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SCRUB_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  domain_demux_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StScrub} state_e;

  localparam logic [3:0] ScrubLoad = 4'(SCRUB_CYCLES - 1);

  state_e           state_q, state_d;
  logic             cur_dom_q, cur_dom_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             hold_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_dom_q <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dom_q <= cur_dom_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // Only the open domain's consumer can release a held word.
  assign hold_ready = cur_dom_q ? bus.out2_ready : bus.out1_ready;

  always_comb begin
    state_d   = state_q;
    cur_dom_d = cur_dom_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.in_sel == cur_dom_q) begin
            data_d  = bus.in_data;
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            cnt_d   = ScrubLoad;
            state_d = StScrub;
          end
        end
      end
      StHold: begin
        if (hold_ready) begin
          data_d  = '0;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      StScrub: begin
        data_d  = '0;
        valid_d = 1'b0;
        if (cnt_q == 4'd0) begin
          cur_dom_d = ~cur_dom_q;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        data_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // data_q is zero outside HOLD, so gating by domain keeps the closed side all-zero.
  assign bus.in_ready   = (state_q == StIdle) && (bus.in_sel == cur_dom_q);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out1_valid = valid_q & ~cur_dom_q;
  assign bus.out2_valid = valid_q & cur_dom_q;
  assign bus.out1_data  = cur_dom_q ? '0 : data_q;
  assign bus.out2_data  = cur_dom_q ? data_q : '0;

endmodule

// File: tb/tb_domain_demux.sv
// Bench for domain_demux: directed vectors, a per-cycle reference model and a delivery
// scoreboard checking words reach the right domain in order.
module tb_domain_demux;
  localparam int unsigned W  = 8;
  localparam int unsigned SC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  domain_demux_if #(.WIDTH(W)) bus ();

  domain_demux #(.WIDTH(W), .SCRUB_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: open domain, whether a word is held, and scrub cycles still to run.
  logic         m_dom;
  logic         m_held;
  logic [W-1:0] m_word;
  int           m_scrub;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dom   <= 1'b0;
      m_held  <= 1'b0;
      m_word  <= '0;
      m_scrub <= 0;
    end else if (m_scrub > 0) begin
      m_scrub <= m_scrub - 1;
      if (m_scrub == 1) m_dom <= ~m_dom;
    end else if (m_held) begin
      if (m_dom ? bus.out2_ready : bus.out1_ready) begin
        m_held <= 1'b0;
        m_word <= '0;
      end
    end else if (bus.in_valid) begin
      if (bus.in_sel == m_dom) begin
        m_held <= 1'b1;
        m_word <= bus.in_data;
      end else begin
        m_scrub <= SC;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(!m_held && m_scrub == 0 && bus.in_sel == m_dom));
    check("busy", 32'(bus.busy), 32'(m_held || m_scrub != 0));
    check("out1_valid", 32'(bus.out1_valid), 32'(m_held && !m_dom));
    check("out2_valid", 32'(bus.out2_valid), 32'(m_held && m_dom));
    check("out1_data", 32'(bus.out1_data), 32'((m_held && !m_dom) ? m_word : '0));
    check("out2_data", 32'(bus.out2_data), 32'((m_held && m_dom) ? m_word : '0));
  end

  // Scoreboard: entries are {domain, data} in acceptance order.
  logic [W:0] sb_q[$];
  int         d1_delivered = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.out1_valid && bus.out1_ready) begin
        d1_delivered <= d1_delivered + 1;
        if (sb_q.size() == 0) check("sb_d1_unexpected", 32'(bus.out1_data), 32'hFFFF_FFFF);
        else check("sb_d1_word", 32'({1'b0, bus.out1_data}), 32'(sb_q.pop_front()));
      end
      if (bus.out2_valid && bus.out2_ready) begin
        if (sb_q.size() == 0) check("sb_d2_unexpected", 32'(bus.out2_data), 32'hFFFF_FFFF);
        else check("sb_d2_word", 32'({1'b1, bus.out2_data}), 32'(sb_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back({bus.in_sel, bus.in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_o1v", 32'(bus.out1_valid), 32'd0);
    check("rst_o2v", 32'(bus.out2_valid), 32'd0);
    check("rst_data", 32'({bus.out1_data, bus.out2_data}), 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int d1_base;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    #2;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_o1v", 32'(bus.out1_valid), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single D1 word.
    step();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'hA5;
    #1 check("d1_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("d1_o1v", 32'(bus.out1_valid), 32'd1);
    check("d1_o1d", 32'(bus.out1_data), 32'hA5);
    check("d1_o2d", 32'(bus.out2_data), 32'd0);
    check("d1_busy", 32'(bus.busy), 32'd1);
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
    check("d1_rel_o1v", 32'(bus.out1_valid), 32'd0);
    check("d1_rel_o1d", 32'(bus.out1_data), 32'd0);
    check("d1_rel_busy", 32'(bus.busy), 32'd0);

    // Switch to D2 with scrub.
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 8'h3C;
    #1 check("sw_rdy0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("sw_scrub_rdy", 32'(bus.in_ready), 32'd0);
      check("sw_scrub_busy", 32'(bus.busy), 32'd1);
      check("sw_scrub_data", 32'({bus.out1_data, bus.out2_data}), 32'd0);
    end
    step();
    check("sw_open_rdy", 32'(bus.in_ready), 32'd1);
    check("sw_open_busy", 32'(bus.busy), 32'd0);
    step();
    check("sw_o2v", 32'(bus.out2_valid), 32'd1);
    check("sw_o2d", 32'(bus.out2_data), 32'h3C);
    check("sw_o1d", 32'(bus.out1_data), 32'd0);

    // Stall in HOLD on D2 while the closed D1 ready toggles.
    bus.in_data = 8'h77;
    for (int i = 0; i < 10; i++) begin
      bus.out1_ready = i[0];
      step();
      check("stall_o2d", 32'(bus.out2_data), 32'h3C);
      check("stall_o2v", 32'(bus.out2_valid), 32'd1);
      check("stall_rdy", 32'(bus.in_ready), 32'd0);
      check("stall_o1v", 32'(bus.out1_valid), 32'd0);
    end
    bus.out1_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.out2_ready = 1'b1;
    step();
    bus.out2_ready = 1'b0;
    check("stall_rel", 32'(bus.out2_valid), 32'd0);

    // Reset during HOLD drops the word.
    pulse_rst();
    step();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    check("hrst_held", 32'(bus.out1_valid), 32'd1);
    pulse_rst();
    step();
    check("hrst_after", 32'(bus.out1_valid), 32'd0);
    sb_q.delete();

    // Reset during SCRUB toward D2, then a fresh scrub.
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 8'hC3;
    step();
    check("srst_busy", 32'(bus.busy), 32'd1);
    pulse_rst();
    check("srst_rdy", 32'(bus.in_ready), 32'd0);
    step();
    check("srst_fresh1", 32'(bus.busy), 32'd1);
    step();
    check("srst_fresh2", 32'(bus.busy), 32'd1);
    step();
    check("srst_open", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("srst_o2d", 32'(bus.out2_data), 32'hC3);
    bus.out2_ready = 1'b1;
    step();
    bus.out2_ready = 1'b0;

    // Back-to-back D1 words, one per two cycles.
    pulse_rst();
    step();
    d1_base = d1_delivered;
    bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      bus.in_data = 8'(w);
      step();
      check("b2b_o1d", 32'(bus.out1_data), 32'(w));
      check("b2b_o2v", 32'(bus.out2_valid), 32'd0);
      step();
      check("b2b_idle", 32'(bus.out1_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    check("b2b_count", 32'(d1_delivered - d1_base), 32'd3);

    // Random traffic against model and scoreboard.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(3) != 0);
      bus.in_sel     = ($urandom_range(3) == 0) ? ~bus.in_sel : bus.in_sel;
      bus.in_data    = 8'($urandom);
      bus.out1_ready = $urandom_range(1) == 1;
      bus.out2_ready = $urandom_range(1) == 1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 2 * SC + 4; i++) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
